// File: rtl/bus_wait_state_ram.sv
// Device-side bus responder: word-addressed RAM answering each request after cfg_wait_i wait states.
// Define BUS_WAIT_STATE_RAM_ERR_EN to flag out-of-range, misaligned and empty-byte-enable writes.
module bus_wait_state_ram #(
   parameter int unsigned             DataWidth    = 32,
   parameter int unsigned             AddressWidth = 32,
   parameter int unsigned             Depth        = 1024,
   parameter logic [AddressWidth-1:0] BaseAddr     = 32'h0010_0000,
   parameter int unsigned             WaitWidth    = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      device_req_i,
   input  logic [AddressWidth-1:0]   device_addr_i,
   input  logic                      device_we_i,
   input  logic [DataWidth/8-1:0]    device_be_i,
   input  logic [DataWidth-1:0]      device_wdata_i,
   output logic                      device_rvalid_o,
   output logic [DataWidth-1:0]      device_rdata_o,
   output logic                      device_err_o,
   input  logic [WaitWidth-1:0]      cfg_wait_i,
   output logic                      busy_o,
   output logic                      overrun_o
);

   // state  | meaning
   // S_IDLE | waiting for a request; only state that accepts one
   // S_WAIT | counting down the wait states latched at accept
   // S_RESP | rvalid/rdata/err presented for one cycle; write lands at end of cycle

   localparam int unsigned IdxW = $clog2(Depth);
   localparam int unsigned BeW  = DataWidth / 8;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                  r_state;
   logic [WaitWidth-1:0]    r_cnt;
   logic [AddressWidth-1:0] r_addr;
   logic                    r_we;
   logic [BeW-1:0]          r_be;
   logic [DataWidth-1:0]    r_wdata;
   logic                    r_rvalid;
   logic [DataWidth-1:0]    r_rdata;
   logic                    r_err;
   logic                    r_busy;
   logic                    r_overrun;
   logic [DataWidth-1:0]    r_mem [Depth];

   logic [AddressWidth-1:0] w_addr;
   logic [AddressWidth-1:0] w_off;
   logic                    w_we;
   logic [BeW-1:0]          w_be;
   logic [IdxW-1:0]         w_idx;
   logic                    w_err;
   logic                    w_accept;
   logic                    w_to_resp;

   // In IDLE the live bus fields drive decode so a zero-wait request resolves at its accept edge.
   always_comb begin
      w_addr = r_addr;
      w_we   = r_we;
      w_be   = r_be;
      if (r_state == S_IDLE) begin
         w_addr = device_addr_i;
         w_we   = device_we_i;
         w_be   = device_be_i;
      end
   end

   assign w_off = w_addr - BaseAddr;
   assign w_idx = w_off[IdxW+1:2];

`ifdef BUS_WAIT_STATE_RAM_ERR_EN
   localparam logic [AddressWidth-1:0] SpanBytes = AddressWidth'(Depth * 4);
   assign w_err = (w_off >= SpanBytes) || (w_addr[1:0] != 2'b00) || (w_we && (w_be == '0));
   assign device_err_o = r_err;
`else
   logic w_unused_bits;
   assign w_err         = 1'b0;
   assign device_err_o  = 1'b0;
   assign w_unused_bits = ^{w_off[AddressWidth-1:IdxW+2], w_off[1:0], w_be};
`endif

   assign w_accept  = (r_state == S_IDLE) && device_req_i;
   assign w_to_resp = (w_accept && (cfg_wait_i == '0)) || ((r_state == S_WAIT) && (r_cnt == '0));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_addr    <= '0;
         r_we      <= 1'b0;
         r_be      <= '0;
         r_wdata   <= '0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_err     <= 1'b0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
         if (device_req_i && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (device_req_i) begin
                  r_addr  <= device_addr_i;
                  r_we    <= device_we_i;
                  r_be    <= device_be_i;
                  r_wdata <= device_wdata_i;
                  r_busy  <= 1'b1;
                  if (cfg_wait_i == '0) begin
                     r_state <= S_RESP;
                  end else begin
                     r_cnt   <= cfg_wait_i - WaitWidth'(1);
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (r_cnt == '0) begin
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - WaitWidth'(1);
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
         if (w_to_resp) begin
            r_rvalid <= 1'b1;
            r_err    <= w_err;
            r_rdata  <= (w_we || w_err) ? '0 : r_mem[w_idx];
         end
      end
   end

   // RAM write commits on the edge closing RESP; an async reset before then discards it.
   always_ff @(posedge clk_i) begin
      if ((r_state == S_RESP) && r_we && !r_err) begin
         for (int b = 0; b < BeW; b++) begin
            if (r_be[b]) begin
               r_mem[w_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
            end
         end
      end
   end

   assign device_rvalid_o = r_rvalid;
   assign device_rdata_o  = r_rdata;
   assign busy_o          = r_busy;
   assign overrun_o       = r_overrun;

endmodule
